// File: rtl/priv_ext_if.sv
// CSR handshake between the privileged unit and an extension CSR file.
// The extension decodes csr_addr and answers combinationally in the same cycle.
interface priv_ext_if;
   logic [11:0] csr_addr;
   logic [31:0] value_in;
   logic        csr_active;
   logic        ack;
   logic        invalid_csr;
   logic [31:0] value_out;

   modport ext (
      input  csr_addr, value_in, csr_active,
      output ack, invalid_csr, value_out
   );

   modport priv (
      output csr_addr, value_in, csr_active,
      input  ack, invalid_csr, value_out
   );
endinterface

// File: rtl/priv_ext_hpm.sv
// Hardware performance-monitor CSRs: counters 3..(2+NUM_COUNTERS), their event
// selectors and read-only user shadows, reached through the extension CSR port.
module priv_ext_hpm #(
   parameter int NUM_COUNTERS = 4,
   parameter int NUM_EVENTS   = 8
) (
   input  logic                    CLK,
   input  logic                    nRST,
   priv_ext_if.ext                 ext_if,
   input  logic [NUM_EVENTS-1:0]   events,
   input  logic [NUM_COUNTERS-1:0] inhibit
);

   logic [63:0]             cnt [NUM_COUNTERS];
   logic [NUM_EVENTS-1:0]   sel [NUM_COUNTERS];
   logic [NUM_EVENTS-1:0]   events_q;

   logic [NUM_COUNTERS-1:0] hit_mlo, hit_mhi, hit_sel, hit_ulo, hit_uhi;
   logic [NUM_COUNTERS-1:0] wr_lo, wr_hi, wr_sel, inc;
   logic [31:0]             rd_data;

   always_comb begin
      hit_mlo = '0;
      hit_mhi = '0;
      hit_sel = '0;
      hit_ulo = '0;
      hit_uhi = '0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         hit_mlo[i] = (ext_if.csr_addr == 12'(12'hB03 + i));
         hit_mhi[i] = (ext_if.csr_addr == 12'(12'hB83 + i));
         hit_sel[i] = (ext_if.csr_addr == 12'(12'h323 + i));
         hit_ulo[i] = (ext_if.csr_addr == 12'(12'hC03 + i));
         hit_uhi[i] = (ext_if.csr_addr == 12'(12'hC83 + i));
      end
   end

   assign wr_lo  = hit_mlo & {NUM_COUNTERS{ext_if.csr_active}};
   assign wr_hi  = hit_mhi & {NUM_COUNTERS{ext_if.csr_active}};
   assign wr_sel = hit_sel & {NUM_COUNTERS{ext_if.csr_active}};

   // One increment per cycle no matter how many selected events fired.
   always_comb begin
      inc = '0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         inc[i] = (|(sel[i] & events_q)) && !inhibit[i];
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         if (hit_mlo[i] || hit_ulo[i]) rd_data = cnt[i][31:0];
         if (hit_mhi[i] || hit_uhi[i]) rd_data = cnt[i][63:32];
         if (hit_sel[i])               rd_data = 32'(sel[i]);
      end
   end

   assign ext_if.ack         = |{hit_mlo, hit_mhi, hit_sel, hit_ulo, hit_uhi};
   assign ext_if.value_out   = rd_data;
   assign ext_if.invalid_csr = ext_if.csr_active && (|{hit_ulo, hit_uhi});

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         events_q <= '0;
      end else begin
         events_q <= events;
      end
   end

   // A CSR write to either half wins over the increment for that cycle.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < NUM_COUNTERS; i++) begin
            cnt[i] <= '0;
            sel[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (wr_lo[i]) begin
               cnt[i][31:0] <= ext_if.value_in;
            end else if (wr_hi[i]) begin
               cnt[i][63:32] <= ext_if.value_in;
            end else if (inc[i]) begin
               cnt[i] <= cnt[i] + 64'd1;
            end
            if (wr_sel[i]) begin
               sel[i] <= NUM_EVENTS'(ext_if.value_in);
            end
         end
      end
   end

endmodule
